// File: rtl/regfile_hilo.sv
// regfile_hilo: 32x32 general-purpose register file plus HI/LO pair.
// Byte-lane-masked writes from writeback commit on the rising edge; the two
// GPR read ports and the HI/LO reads are combinational and bypass the write
// currently presented by writeback, so decode never sees stale data.
// gpr[0] is not stored and always reads zero. While rst is high every
// output is held at zero and no write is committed.

module regfile_hilo (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  wb_wren_i,
   input  logic [4:0]  wb_waddr_i,
   input  logic [31:0] wb_wdata_i,
   input  logic        wb_whien_i,
   input  logic        wb_wloen_i,
   input  logic [31:0] wb_hi_i,
   input  logic [31:0] wb_lo_i,
   input  logic [4:0]  id_raddr1_i,
   input  logic [4:0]  id_raddr2_i,
   output logic [31:0] id_rdata1_o,
   output logic [31:0] id_rdata2_o,
   output logic [31:0] id_hi_o,
   output logic [31:0] id_lo_o
);

   // Stored registers 1..31; index 0 is the hard-wired zero register.
   logic [31:0] gpr [1:31];
   logic [31:0] hi;
   logic [31:0] lo;

   // Full 0..31 view of the register file so reads never index outside storage.
   logic [31:0] gpr_view [0:31];

   // Replace each byte of old_data whose enable bit is set with the matching byte of new_data.
   function automatic logic [31:0] byte_merge(
      input logic [3:0]  en,
      input logic [31:0] new_data,
      input logic [31:0] old_data
   );
      logic [31:0] merged;
      merged = old_data;
      for (int b = 0; b < 4; b++) begin
         if (en[b]) begin
            merged[8*b +: 8] = new_data[8*b +: 8];
         end else begin
            merged[8*b +: 8] = old_data[8*b +: 8];
         end
      end
      return merged;
   endfunction

   // One GPR read port: zero register, then same-cycle bypass merge, then stored value.
   function automatic logic [31:0] read_gpr(
      input logic [4:0]  raddr,
      input logic [31:0] stored,
      input logic [4:0]  waddr,
      input logic [3:0]  wren,
      input logic [31:0] wdata
   );
      logic [31:0] value;
      if (raddr == 5'd0) begin
         value = 32'h0000_0000;
      end else if ((raddr == waddr) && (wren != 4'b0000)) begin
         value = byte_merge(wren, wdata, stored);
      end else begin
         value = stored;
      end
      return value;
   endfunction

   // Commit byte-masked GPR writes; address 0 matches no stored register and is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r < 32; r++) begin
            gpr[r] <= 32'h0000_0000;
         end
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (wb_waddr_i == 5'(r)) begin
               gpr[r] <= byte_merge(wb_wren_i, wb_wdata_i, gpr[r]);
            end
         end
      end
   end

   // Commit HI and LO writes independently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= 32'h0000_0000;
         lo <= 32'h0000_0000;
      end else begin
         if (wb_whien_i) begin
            hi <= wb_hi_i;
         end
         if (wb_wloen_i) begin
            lo <= wb_lo_i;
         end
      end
   end

   // Build the zero-padded read view of the register file.
   always_comb begin
      gpr_view[0] = 32'h0000_0000;
      for (int r = 1; r < 32; r++) begin
         gpr_view[r] = gpr[r];
      end
   end

   // Combinational read ports with write-through bypass, forced to zero during reset.
   always_comb begin
      id_rdata1_o = 32'h0000_0000;
      id_rdata2_o = 32'h0000_0000;
      id_hi_o     = 32'h0000_0000;
      id_lo_o     = 32'h0000_0000;
      if (rst) begin
         id_rdata1_o = 32'h0000_0000;
         id_rdata2_o = 32'h0000_0000;
         id_hi_o     = 32'h0000_0000;
         id_lo_o     = 32'h0000_0000;
      end else begin
         id_rdata1_o = read_gpr(id_raddr1_i, gpr_view[id_raddr1_i],
                                wb_waddr_i, wb_wren_i, wb_wdata_i);
         id_rdata2_o = read_gpr(id_raddr2_i, gpr_view[id_raddr2_i],
                                wb_waddr_i, wb_wren_i, wb_wdata_i);
         id_hi_o     = wb_whien_i ? wb_hi_i : hi;
         id_lo_o     = wb_wloen_i ? wb_lo_i : lo;
      end
   end

endmodule
